ber_checker: RTL and testbench
==============================

Name: ber_checker

Overview:
- Receive-side end of the BPSK test link: consumes the filtered, oversampled TX stream (OV_SAMP samples per symbol) and picks one sample per symbol at a switch-selected phase.
- Slices that sample to a bit and aligns it against the transmitted PRBS reference bit stream by sweeping a programmable delay.
- Once aligned, accumulates bit and error counts for BER readout.
- Sits beside the TX filter/downsampler in topLevel; the counters feed the LEDs/VIO.

Parameters:
- NB_INPUT, 8, sample width (signed).
- NBF_INPUT, 7, sample fractional bits (informational; only the MSB is used).
- OV_SAMP, 4, samples per symbol (power of 2).
- NB_PHASE, 2, log2(OV_SAMP).
- NB_DELAY, 9, reference delay-line address width; depth 2^NB_DELAY = 512.
- WINDOW, 511, symbols per alignment/lock-check window.
- LOSS_THR, 32, window error count at or above which lock is lost.
- NB_COUNT, 64, bit/error counter width.

Ports:
- clock, in, 1, system clock (sample rate, T/OV_SAMP).
- i_reset, in, 1, synchronous active-low reset.
- i_enable, in, 1, run enable (sw[0]).
- i_phase, in, NB_PHASE, sampling phase select (sw[3:2]).
- i_sample, in, NB_INPUT, signed filtered sample, one per clock.
- i_ref_bit, in, 1, TX PRBS bit; valid when the phase counter is 0.
- o_synced, out, 1, alignment found.
- o_delay, out, NB_DELAY, current or locked reference delay.
- o_bit_count, out, NB_COUNT, compared bits while synced.
- o_err_count, out, NB_COUNT, mismatches while synced.

Behaviour:
- Reset (i_reset=0 at posedge):
  - state=IDLE, phase counter=0, delay=0, window counters=0.
  - Delay line cleared to 0; all outputs 0.
  - Reset overrides every other input and takes effect on the same edge, including mid-window or mid-lock.
- Phase counter:
  - Free-runs 0..OV_SAMP-1, wrapping, while i_enable=1.
  - Forced to 0 while i_enable=0.
- Reference strobe (counter==0): shift i_ref_bit into the 512-deep delay line; position 0 is the newest bit.
- Decision strobe (counter==i_phase): rx_bit = i_sample[NB_INPUT-1] (negative sample -> 1).
  - Compare rx_bit with delay_line[o_delay] as held before this edge.
  - If counter==0 and i_phase==0 on the same edge, read the line before the shift.
- i_phase changes take effect on the next decision strobe. There is no forced resync; any lock loss is detected through the error threshold.
- FSM:
  - IDLE: entered whenever i_enable=0; o_synced=0; counters held. On i_enable=1, go to SEARCH with delay=0 and window counters cleared.
  - SEARCH: each decision strobe increments win_sym, and win_err on mismatch. When win_sym reaches WINDOW:
    - win_err==0: go to LOCKED, keeping the current delay.
    - otherwise: delay=delay+1, wrapping 511->0.
    - Either way, clear the window counters.
  - LOCKED: o_synced=1. Each decision strobe increments o_bit_count, and o_err_count on mismatch. Window counting continues; at window end:
    - win_err >= LOSS_THR: go to SEARCH, delay=delay+1, o_synced=0 on the next cycle.
    - otherwise stay in LOCKED.
    - Clear the window counters either way.
- Counter width rules:
  - o_bit_count and o_err_count saturate at all-ones and never wrap.
  - They are cleared only by reset and held through IDLE and SEARCH.
  - win_sym and win_err are 9 bits; win_err saturates.
- Latency: one decision strobe enters the counters on the clock edge of that strobe. o_synced rises on the edge that completes the first clean window.

Decomposition:
- Package ber_pkg:
  - State encoding IDLE/SEARCH/LOCKED (2-bit).
  - WINDOW, LOSS_THR and delay-depth constants.
  - The sat_inc function.
- One natural sub-module, ref_delay_line: a 512x1 shift register with a combinational tap read.
  - Ports: clock, i_reset, i_shift, i_bit, i_addr, o_bit.
- FSM, phase counter and counters stay in ber_checker.

Test Plan:
- Reset check: hold i_reset=0 for 10 cycles with random inputs -> all outputs 0, o_synced=0.
- Lock at delay 0:
  - Stimulus: PRBS9 reference, i_sample=+64 for bit 0 and -64 for bit 1, sample aligned to the reference, i_phase=0.
  - Response: o_synced=1 after 511 symbols (2044 clocks), o_delay=0, o_err_count stays 0, o_bit_count increments once per 4 clocks.
- Delay sweep:
  - Stimulus: sample stream lagging the reference by 5 symbols.
  - Response: SEARCH steps delay 0..5; lock at o_delay=5 after 6x511 symbols; zero errors afterwards.
- Error injection while locked: invert every 100th sliced bit -> o_err_count/o_bit_count ≈ 1/100; lock held, since 5 errors per window < LOSS_THR.
- Lock loss:
  - Stimulus: while locked, change i_phase to 2 with an input that is valid only at phase 0, so roughly 50% errors.
  - Response: o_synced falls at the end of the window; o_delay increments; counters frozen.
- Enable/reset mid-run:
  - i_enable=0 while locked -> IDLE, counters held. On re-enable, search restarts at delay 0 and counting resumes from the held values.
  - i_reset=0 mid-SEARCH -> all cleared on the next edge.

Source files
------------

// File: rtl/ber_pkg.sv
// Shared constants, FSM encoding and saturating counter helper for the BER checker.
package ber_pkg;

  localparam int unsigned NB_INPUT    = 8;
  localparam int unsigned OV_SAMP     = 4;
  localparam int unsigned NB_PHASE    = 2;
  localparam int unsigned NB_DELAY    = 9;
  localparam int unsigned DELAY_DEPTH = 1 << NB_DELAY;
  localparam int unsigned NB_WIN      = 9;
  localparam int unsigned WINDOW      = 511;
  localparam int unsigned LOSS_THR    = 32;
  localparam int unsigned NB_COUNT    = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Increment when asked, sticking at all-ones instead of wrapping.
  function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] value,
                                                  input logic               en);
    return (en && !(&value)) ? value + NB_COUNT'(1) : value;
  endfunction

endpackage

// File: rtl/ber_if.sv
// Sample/reference inputs and BER status outputs of the receive-side checker.
interface ber_if;
  import ber_pkg::*;

  logic                       i_enable;
  logic [NB_PHASE-1:0]        i_phase;
  logic signed [NB_INPUT-1:0] i_sample;
  logic                       i_ref_bit;
  logic                       o_synced;
  logic [NB_DELAY-1:0]        o_delay;
  logic [NB_COUNT-1:0]        o_bit_count;
  logic [NB_COUNT-1:0]        o_err_count;

  modport master (
    output i_enable, i_phase, i_sample, i_ref_bit,
    input  o_synced, o_delay, o_bit_count, o_err_count
  );

  modport slave (
    input  i_enable, i_phase, i_sample, i_ref_bit,
    output o_synced, o_delay, o_bit_count, o_err_count
  );

endinterface

// File: rtl/ber_checker_ref_delay_line.sv
// Reference PRBS history: 512x1 shift register, position 0 newest, tap read combinationally.
module ref_delay_line
  import ber_pkg::*;
(
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_shift,
  input  logic                i_bit,
  input  logic [NB_DELAY-1:0] i_addr,
  output logic                o_bit
);

  logic [DELAY_DEPTH-1:0] line;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      line <= '0;
    end else if (i_shift) begin
      line <= {line[DELAY_DEPTH-2:0], i_bit};
    end
  end

  assign o_bit = line[i_addr];

endmodule

// File: rtl/ber_checker.sv
// BPSK receive-side BER checker: phase-selected slicing, reference delay sweep,
// lock detection and saturating bit/error counters.
module ber_checker
  import ber_pkg::*;
(
  input  logic  clock,
  input  logic  i_reset,
  ber_if.slave  bus
);

  state_t              state, state_n;
  logic [NB_PHASE-1:0] phase_cnt, phase_cnt_n;
  logic [NB_DELAY-1:0] delay, delay_n;
  logic [NB_WIN-1:0]   win_sym, win_sym_n, win_err, win_err_n;
  logic [NB_COUNT-1:0] bit_cnt, bit_cnt_n, err_cnt, err_cnt_n;
  logic                synced;

  logic                ref_strobe, dec_strobe, ref_tap, mismatch, win_end;
  logic [NB_WIN-1:0]   win_sym_inc, win_err_inc;
  logic                unused_sample_bits;

  assign unused_sample_bits = ^bus.i_sample[NB_INPUT-2:0];

  // Tap is read before this edge's shift, so phase 0 sees the previous history.
  ref_delay_line u_ref_delay_line (
    .clock   (clock),
    .i_reset (i_reset),
    .i_shift (ref_strobe),
    .i_bit   (bus.i_ref_bit),
    .i_addr  (delay),
    .o_bit   (ref_tap)
  );

  assign ref_strobe  = bus.i_enable && (phase_cnt == '0);
  assign dec_strobe  = bus.i_enable && (phase_cnt == bus.i_phase);
  assign mismatch    = bus.i_sample[NB_INPUT-1] ^ ref_tap;
  assign win_sym_inc = win_sym + NB_WIN'(1);
  assign win_err_inc = (mismatch && !(&win_err)) ? win_err + NB_WIN'(1) : win_err;
  assign win_end     = (win_sym_inc == NB_WIN'(WINDOW));

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state     <= IDLE;
      phase_cnt <= '0;
      delay     <= '0;
      win_sym   <= '0;
      win_err   <= '0;
      bit_cnt   <= '0;
      err_cnt   <= '0;
      synced    <= 1'b0;
    end else begin
      state     <= state_n;
      phase_cnt <= phase_cnt_n;
      delay     <= delay_n;
      win_sym   <= win_sym_n;
      win_err   <= win_err_n;
      bit_cnt   <= bit_cnt_n;
      err_cnt   <= err_cnt_n;
      synced    <= (state_n == LOCKED);
    end
  end

  // Next-state and counter update; window end accounts for the current strobe.
  always_comb begin
    state_n   = state;
    delay_n   = delay;
    win_sym_n = win_sym;
    win_err_n = win_err;
    bit_cnt_n = bit_cnt;
    err_cnt_n = err_cnt;

    if (!bus.i_enable) begin
      phase_cnt_n = '0;
    end else if (phase_cnt == NB_PHASE'(OV_SAMP - 1)) begin
      phase_cnt_n = '0;
    end else begin
      phase_cnt_n = phase_cnt + NB_PHASE'(1);
    end

    if (!bus.i_enable) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          state_n   = SEARCH;
          delay_n   = '0;
          win_sym_n = '0;
          win_err_n = '0;
        end
        SEARCH: begin
          if (dec_strobe) begin
            if (win_end) begin
              win_sym_n = '0;
              win_err_n = '0;
              if (win_err_inc == '0) begin
                state_n = LOCKED;
              end else begin
                delay_n = delay + NB_DELAY'(1);
              end
            end else begin
              win_sym_n = win_sym_inc;
              win_err_n = win_err_inc;
            end
          end
        end
        LOCKED: begin
          if (dec_strobe) begin
            bit_cnt_n = sat_inc(bit_cnt, 1'b1);
            err_cnt_n = sat_inc(err_cnt, mismatch);
            if (win_end) begin
              win_sym_n = '0;
              win_err_n = '0;
              if (win_err_inc >= NB_WIN'(LOSS_THR)) begin
                state_n = SEARCH;
                delay_n = delay + NB_DELAY'(1);
              end
            end else begin
              win_sym_n = win_sym_inc;
              win_err_n = win_err_inc;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.o_synced    = synced;
  assign bus.o_delay     = delay;
  assign bus.o_bit_count = bit_cnt;
  assign bus.o_err_count = err_cnt;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker: per-cycle scoreboard against a symbol-history model
// plus directed checks on lock timing, sweep, error injection, lock loss and enable/reset.
module tb_ber_checker;
  import ber_pkg::*;

  logic clock   = 1'b0;
  logic i_reset = 1'b0;

  ber_if bus();

  ber_checker dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic                synced;
    logic [NB_DELAY-1:0] delay;
    logic [NB_COUNT-1:0] bits;
    logic [NB_COUNT-1:0] errs;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: state 0 idle, 1 search, 2 locked; reference history kept by shift index.
  int              m_state, m_cnt, m_delay, m_wsym, m_werr;
  longint unsigned m_bits, m_errs;
  bit              shifted [0:16383];
  int              nshift;

  // Stimulus stream.
  bit       gen [0:16383];
  int       nsym;
  int       lag;
  bit       inject, noise, rand_in;
  bit [8:0] lfsr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic restart_stream();
    nsym = 0;
    lfsr = 9'h1FF;
  endtask

  // PRBS9, x^9 + x^5 + 1
  task automatic prbs_next(output bit b);
    b    = lfsr[8];
    lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
  endtask

  task automatic set_inputs();
    bit b;
    bit sb;
    int idx;
    if (rand_in) begin
      bus.i_enable  = 1'($urandom);
      bus.i_phase   = 2'($urandom);
      bus.i_sample  = 8'($urandom);
      bus.i_ref_bit = 1'($urandom);
      return;
    end
    if (bus.i_enable && i_reset && m_cnt == 0) begin
      prbs_next(b);
      gen[nsym] = b;
      nsym++;
      bus.i_ref_bit = b;
    end
    idx = nsym - 2 - lag;
    sb  = (idx >= 0) ? gen[idx] : 1'b0;
    if (inject && nsym > 0 && ((nsym - 1) % 100 == 0)) sb = ~sb;
    if (noise && m_cnt != 0) sb = 1'($urandom);
    bus.i_sample = sb ? 8'hC0 : 8'h40;
  endtask

  task automatic model_step();
    bit en, ref_s, dec_s, tap, mis;
    int ti;
    if (!i_reset) begin
      m_state = 0; m_cnt = 0; m_delay = 0; m_wsym = 0; m_werr = 0;
      m_bits = 0; m_errs = 0; nshift = 0;
      return;
    end
    en    = bus.i_enable;
    ref_s = en && (m_cnt == 0);
    dec_s = en && (m_cnt == int'(bus.i_phase));
    ti    = nshift - 1 - m_delay;
    tap   = (ti >= 0) ? shifted[ti] : 1'b0;
    mis   = bus.i_sample[7] != tap;
    if (!en) begin
      m_state = 0;
    end else if (m_state == 0) begin
      m_state = 1; m_delay = 0; m_wsym = 0; m_werr = 0;
    end else if (dec_s) begin
      if (m_state == 2) begin
        if (m_bits != 64'hFFFF_FFFF_FFFF_FFFF) m_bits++;
        if (mis && m_errs != 64'hFFFF_FFFF_FFFF_FFFF) m_errs++;
      end
      m_wsym++;
      if (mis) m_werr++;
      if (m_wsym == int'(WINDOW)) begin
        if (m_state == 1 && m_werr == 0) begin
          m_state = 2;
        end else if (m_state == 1 || m_werr >= int'(LOSS_THR)) begin
          m_state = 1;
          m_delay = (m_delay + 1) % 512;
        end
        m_wsym = 0;
        m_werr = 0;
      end
    end
    if (ref_s) begin
      shifted[nshift] = bus.i_ref_bit;
      nshift++;
    end
    m_cnt = en ? (m_cnt + 1) % 4 : 0;
  endtask

  // One clock: drive, predict, push; after the edge pop and compare.
  task automatic tick();
    exp_t e;
    set_inputs();
    model_step();
    e.synced = (m_state == 2);
    e.delay  = NB_DELAY'(m_delay);
    e.bits   = m_bits;
    e.errs   = m_errs;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk("sb_synced", 64'(bus.o_synced), 64'(e.synced));
    chk("sb_delay",  64'(bus.o_delay),  64'(e.delay));
    chk("sb_bits",   bus.o_bit_count,   e.bits);
    chk("sb_errs",   bus.o_err_count,   e.errs);
  endtask

  task automatic wait_synced(input logic want, input int budget, output int n);
    n = 0;
    while (bus.o_synced !== want && n < budget) begin
      tick();
      n++;
    end
    chk("wait_synced", 64'(bus.o_synced), 64'(want));
  endtask

  initial begin
    longint unsigned b0, e0, db, de;
    int              n;

    bus.i_enable = 1'b0; bus.i_phase = '0; bus.i_sample = '0; bus.i_ref_bit = 1'b0;
    lag = 0; inject = 0; noise = 0; rand_in = 1;
    restart_stream();

    // Reset with random inputs
    repeat (10) tick();
    chk("rst_synced", 64'(bus.o_synced), 64'd0);
    chk("rst_delay",  64'(bus.o_delay),  64'd0);
    chk("rst_bits",   bus.o_bit_count,   64'd0);
    chk("rst_errs",   bus.o_err_count,   64'd0);

    // Lock at delay 0: first clean window completes on the 2045th enabled edge
    rand_in = 0;
    bus.i_enable = 1'b1; bus.i_phase = 2'd0; bus.i_ref_bit = 1'b0;
    i_reset = 1'b1;
    repeat (2044) tick();
    chk("prelock_synced", 64'(bus.o_synced), 64'd0);
    tick();
    chk("lock_synced", 64'(bus.o_synced), 64'd1);
    chk("lock_delay",  64'(bus.o_delay),  64'd0);
    repeat (400) tick();
    chk("lock_bits", bus.o_bit_count, 64'd100);
    chk("lock_errs", bus.o_err_count, 64'd0);

    // Error injection every 100th symbol
    b0 = bus.o_bit_count; e0 = bus.o_err_count;
    inject = 1;
    repeat (3 * 2044) tick();
    inject = 0;
    db = bus.o_bit_count - b0; de = bus.o_err_count - e0;
    chk("inj_synced", 64'(bus.o_synced), 64'd1);
    chk("inj_ratio", 64'((de * 100 + 100 >= db) && (de * 100 <= db + 100) && de > 0), 64'd1);

    // Disable while locked: counters hold
    bus.i_enable = 1'b0;
    tick();
    chk("dis_synced", 64'(bus.o_synced), 64'd0);
    b0 = bus.o_bit_count; e0 = bus.o_err_count;
    repeat (20) tick();
    chk("dis_bits_held", bus.o_bit_count, b0);
    chk("dis_errs_held", bus.o_err_count, e0);

    // Re-enable: search restarts at delay 0, counting resumes from held values
    bus.i_enable = 1'b1;
    tick();
    chk("reen_delay",  64'(bus.o_delay),  64'd0);
    chk("reen_synced", 64'(bus.o_synced), 64'd0);
    chk("reen_bits_held", bus.o_bit_count, b0);
    wait_synced(1'b1, 2100, n);
    chk("reen_lock_cycles", 64'(n), 64'd2044);
    repeat (40) tick();
    chk("reen_bits_resume", 64'(bus.o_bit_count > b0), 64'd1);

    // Lock loss: decision moved to phase 2 where the input is noise
    e0 = bus.o_err_count;
    bus.i_phase = 2'd2; noise = 1;
    wait_synced(1'b0, 3 * 2044, n);
    chk("loss_delay", 64'(bus.o_delay), 64'd1);
    chk("loss_errs_grew", 64'(bus.o_err_count > e0), 64'd1);
    b0 = bus.o_bit_count; e0 = bus.o_err_count;
    repeat (100) tick();
    chk("loss_bits_frozen", bus.o_bit_count, b0);
    chk("loss_errs_frozen", bus.o_err_count, e0);

    // Reset mid-SEARCH clears everything on the next edge
    i_reset = 1'b0;
    tick();
    chk("rst2_delay", 64'(bus.o_delay), 64'd0);
    chk("rst2_bits",  bus.o_bit_count,  64'd0);
    chk("rst2_errs",  bus.o_err_count,  64'd0);

    // Delay sweep: stream lags by 5 symbols, lock after 6 windows
    restart_stream();
    lag = 5; noise = 0; bus.i_phase = 2'd0; bus.i_enable = 1'b1;
    i_reset = 1'b1;
    wait_synced(1'b1, 13000, n);
    chk("sweep_lock_cycles", 64'(n), 64'd12265);
    chk("sweep_delay", 64'(bus.o_delay), 64'd5);
    repeat (400) tick();
    chk("sweep_bits", bus.o_bit_count, 64'd100);
    chk("sweep_errs", bus.o_err_count, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
